// File: rtl/ball_pkg.sv
// Shared types and constants for the ball sprite control blocks.
//   sched_state_t : scheduler state encoding (SERVE/RUN/PAUSE/OVER)
//   H_ACTIVE/V_ACTIVE : visible screen size in pixels/lines
//   DIV_MIN       : fastest allowed frames-per-step
//   div_dec()     : saturating decrement of a frames-per-step value
package ball_pkg;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } sched_state_t;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;

  localparam int unsigned SCAN_W  = 10;
  localparam int unsigned DIV_W   = 4;
  localparam int unsigned LIVES_W = 2;
  localparam int unsigned RUNF_W  = 10;
  localparam int unsigned DIV_MIN = 1;

  // One level faster, never below DIV_MIN.
  function automatic logic [DIV_W-1:0] div_dec(input logic [DIV_W-1:0] d);
    return (d > DIV_W'(DIV_MIN)) ? d - DIV_W'(1) : DIV_W'(DIV_MIN);
  endfunction

endpackage

// File: rtl/ball_move_sched_edge_rise.sv
// Registered rising-edge detector for debounced button levels.
//   clk, rst : clock, synchronous active-high reset
//   d        : input level
//   rise_c   : high while d is 1 and its registered previous value is 0
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise_c
);

  logic prev_q;
  logic prev_d;

  always_comb prev_d = d;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= prev_d;
  end

  assign rise_c = d & ~prev_q;

endmodule

// File: rtl/ball_move_sched.sv
// Frame-level scheduler for the bouncing ball: issues at most one move per
// frame in vertical blank, runs the serve/run/pause/over state machine and
// tracks lives and speed.
// Optional macro BALL_SCHED_AUTOSPEED_EN adds automatic speed-up every
// SPEEDUP_FRAMES frames spent in RUN.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   pixpulse          : pixel enable (1 clk in 4)
//   hcount, vcount    : scan position from the VGA timing generator
//   serve_btn         : debounced level, rising edge serves / restarts
//   pause_btn         : debounced level, rising edge toggles pause
//   speed_up          : 1-clk pulse, one level faster
//   miss              : ball left the playfield, sampled on frame tick
//   move              : step request to the ball (spans one pixpulse)
//   ball_rst          : 1-clk pulse reloading the ball start position
//   state             : 0=SERVE 1=RUN 2=PAUSE 3=OVER
//   lives             : lives remaining
//   frame_div         : frames per ball step
//   frame_tick        : 1-clk pulse once per frame
module ball_move_sched
  import ball_pkg::*;
#(
  parameter int unsigned MOVE_LINE      = 490,
  parameter int unsigned LIVES          = 3,
  parameter int unsigned DIV_INIT       = 4,
  parameter int unsigned SPEEDUP_FRAMES = 600
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pixpulse,
  input  logic [SCAN_W-1:0] hcount,
  input  logic [SCAN_W-1:0] vcount,
  input  logic              serve_btn,
  input  logic              pause_btn,
  input  logic              speed_up,
  input  logic              miss,
  output logic              move,
  output logic              ball_rst,
  output logic [1:0]        state,
  output logic [LIVES_W-1:0] lives,
  output logic [DIV_W-1:0]  frame_div,
  output logic              frame_tick
);

  // Elaboration-time parameter range checks.
  if (MOVE_LINE < V_ACTIVE || MOVE_LINE > 1023) begin : g_bad_move_line
    $error("MOVE_LINE must lie in vertical blank (480..1023)");
  end
  if (LIVES < 1 || LIVES > 3) begin : g_bad_lives
    $error("LIVES must be 1..3");
  end
  if (DIV_INIT < DIV_MIN || DIV_INIT > 15) begin : g_bad_div_init
    $error("DIV_INIT must be 1..15");
  end
  if (SPEEDUP_FRAMES < 1 || SPEEDUP_FRAMES > 1023) begin : g_bad_speedup
    $error("SPEEDUP_FRAMES must be 1..1023");
  end

  sched_state_t        state_q, state_d;
  logic [LIVES_W-1:0]  lives_q, lives_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic                move_q, move_d;
  logic                ball_rst_q, ball_rst_d;
  logic                frame_tick_q, frame_tick_d;
`ifdef BALL_SCHED_AUTOSPEED_EN
  logic [RUNF_W-1:0]   run_q, run_d;
`endif

  logic                serve_rise_c;
  logic                pause_rise_c;
  logic [DIV_W:0]      cnt_plus1_c;
  logic                step_c;
  logic                reload_c;
  logic                dec_c;

  edge_rise u_serve_edge (
    .clk    (clk),
    .rst    (rst),
    .d      (serve_btn),
    .rise_c (serve_rise_c)
  );

  edge_rise u_pause_edge (
    .clk    (clk),
    .rst    (rst),
    .d      (pause_btn),
    .rise_c (pause_rise_c)
  );

  assign cnt_plus1_c = {1'b0, cnt_q} + (DIV_W+1)'(1);

  // Next-state, counters and output pulses.
  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    cnt_d        = cnt_q;
    ball_rst_d   = 1'b0;
    step_c       = 1'b0;
    reload_c     = 1'b0;
    dec_c        = speed_up;
`ifdef BALL_SCHED_AUTOSPEED_EN
    run_d        = run_q;
`endif

    frame_tick_d = pixpulse && (hcount == '0) && (vcount == SCAN_W'(MOVE_LINE));

    case (state_q)
      ST_SERVE: begin
        if (serve_rise_c) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          reload_c = 1'b1;
        end
      end
      ST_RUN: begin
        // A miss on the tick wins over a pause edge and suppresses the step.
        if (frame_tick_q && miss) begin
          lives_d    = lives_q - LIVES_W'(1);
          ball_rst_d = 1'b1;
          state_d    = (lives_q > LIVES_W'(1)) ? ST_SERVE : ST_OVER;
`ifdef BALL_SCHED_AUTOSPEED_EN
          run_d      = '0;
`endif
        end else if (pause_rise_c) begin
          state_d = ST_PAUSE;
        end else if (frame_tick_q) begin
`ifdef BALL_SCHED_AUTOSPEED_EN
          if (run_q == RUNF_W'(SPEEDUP_FRAMES - 1)) begin
            run_d = '0;
            dec_c = 1'b1;
          end else begin
            run_d = run_q + RUNF_W'(1);
          end
`endif
          if (cnt_plus1_c >= {1'b0, div_q}) begin
            cnt_d  = '0;
            step_c = 1'b1;
          end else begin
            cnt_d = cnt_plus1_c[DIV_W-1:0];
          end
        end
      end
      ST_PAUSE: begin
        // Frame counter is kept so the step cadence resumes where it left off.
        if (pause_rise_c) state_d = ST_RUN;
      end
      ST_OVER: begin
        if (serve_rise_c) begin
          state_d    = ST_SERVE;
          lives_d    = LIVES_W'(LIVES);
          ball_rst_d = 1'b1;
          reload_c   = 1'b1;
`ifdef BALL_SCHED_AUTOSPEED_EN
          run_d      = '0;
`endif
        end
      end
      default: state_d = ST_SERVE;
    endcase

    // A reload overrides any simultaneous decrement.
    if (reload_c)   div_d = DIV_W'(DIV_INIT);
    else if (dec_c) div_d = div_dec(div_q);
    else            div_d = div_q;

    // Hold move until the ball has seen one pixpulse-qualified clk.
    if (step_c)                  move_d = 1'b1;
    else if (move_q && pixpulse) move_d = 1'b0;
    else                         move_d = move_q;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_SERVE;
      lives_q      <= LIVES_W'(LIVES);
      div_q        <= DIV_W'(DIV_INIT);
      cnt_q        <= '0;
      move_q       <= 1'b0;
      ball_rst_q   <= 1'b0;
      frame_tick_q <= 1'b0;
`ifdef BALL_SCHED_AUTOSPEED_EN
      run_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      move_q       <= move_d;
      ball_rst_q   <= ball_rst_d;
      frame_tick_q <= frame_tick_d;
`ifdef BALL_SCHED_AUTOSPEED_EN
      run_q        <= run_d;
`endif
    end
  end

  assign move       = move_q;
  assign ball_rst   = ball_rst_q;
  assign state      = state_q;
  assign lives      = lives_q;
  assign frame_div  = div_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ball_move_sched.sv
// Self-checking bench for ball_move_sched with a compressed scan (4 pixels x
// 11 lines around MOVE_LINE) and an event-level reference model.
module tb_ball_move_sched;

  localparam int MOVE_LINE  = 490;
  localparam int LIVES      = 3;
  localparam int DIV_INIT   = 4;
  localparam int SF         = 8;
  localparam int H_TOT      = 4;
  localparam int V_FIRST    = 485;
  localparam int V_LAST     = 495;
  localparam int FRAME_CLKS = 4 * H_TOT * (V_LAST - V_FIRST + 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pixpulse = 1'b0;
  logic [9:0] hcount = '0;
  logic [9:0] vcount = 10'(V_FIRST);
  logic       serve_btn = 1'b0;
  logic       pause_btn = 1'b0;
  logic       speed_up = 1'b0;
  logic       miss = 1'b0;
  logic       move;
  logic       ball_rst;
  logic [1:0] state;
  logic [1:0] lives;
  logic [3:0] frame_div;
  logic       frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  ball_move_sched #(
    .MOVE_LINE      (MOVE_LINE),
    .LIVES          (LIVES),
    .DIV_INIT       (DIV_INIT),
    .SPEEDUP_FRAMES (SF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pixpulse   (pixpulse),
    .hcount     (hcount),
    .vcount     (vcount),
    .serve_btn  (serve_btn),
    .pause_btn  (pause_btn),
    .speed_up   (speed_up),
    .miss       (miss),
    .move       (move),
    .ball_rst   (ball_rst),
    .state      (state),
    .lives      (lives),
    .frame_div  (frame_div),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Compressed scan generator: hcount advances after each pixpulse.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (pixpulse) begin
        if (hcount == 10'(H_TOT - 1)) begin
          hcount = '0;
          vcount = (vcount == 10'(V_LAST)) ? 10'(V_FIRST) : vcount + 10'd1;
        end else begin
          hcount = hcount + 10'd1;
        end
      end
      ph = (ph + 1) % 4;
      pixpulse = (ph == 0);
    end
  end

  // Reference model: game rules applied to the inputs the bench drives.
  int m_state = 0, m_lives = LIVES, m_div = DIV_INIT, m_cnt = 0, m_run = 0;
  int m_ft = 0, m_brst = 0, m_psb = 0, m_ppb = 0;
  int m_steps = 0, n_frames = 0;

  task automatic model_clk();
    int tc, se, pe, dec, reload, ft_old;
    tc = (pixpulse && hcount == 10'd0 && vcount == 10'(MOVE_LINE)) ? 1 : 0;
    if (rst) begin
      m_state = 0; m_lives = LIVES; m_div = DIV_INIT; m_cnt = 0; m_run = 0;
      m_ft = 0; m_brst = 0; m_psb = 0; m_ppb = 0;
    end else begin
      se = (serve_btn && m_psb == 0) ? 1 : 0;
      pe = (pause_btn && m_ppb == 0) ? 1 : 0;
      m_psb = serve_btn ? 1 : 0;
      m_ppb = pause_btn ? 1 : 0;
      ft_old = m_ft;
      m_ft = tc;
      m_brst = 0;
      dec = speed_up ? 1 : 0;
      reload = 0;
      if (ft_old != 0) n_frames++;
      case (m_state)
        0: if (se != 0) begin m_state = 1; m_cnt = 0; reload = 1; end
        1: begin
          if (ft_old != 0 && miss) begin
            m_lives = m_lives - 1;
            m_brst = 1;
            m_state = (m_lives == 0) ? 3 : 0;
            m_run = 0;
          end else if (pe != 0) begin
            m_state = 2;
          end else if (ft_old != 0) begin
`ifdef BALL_SCHED_AUTOSPEED_EN
            m_run = m_run + 1;
            if (m_run == SF) begin m_run = 0; dec = 1; end
`endif
            if (m_cnt + 1 >= m_div) begin m_cnt = 0; m_steps++; end
            else m_cnt = m_cnt + 1;
          end
        end
        2: if (pe != 0) m_state = 1;
        default: if (se != 0) begin
          m_state = 0; m_lives = LIVES; reload = 1; m_brst = 1; m_run = 0;
        end
      endcase
      if (reload != 0) m_div = DIV_INIT;
      else if (dec != 0 && m_div > 1) m_div = m_div - 1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_clk();
  end

  // Per-clk output tracking and move pulse shape checks.
  int n_move_rise = 0, n_brst_rise = 0;
  initial begin
    int mv_prev, ft_prev, br_prev, pp, trunc;
    mv_prev = 0; ft_prev = 0; br_prev = 0; pp = 0; trunc = 0;
    forever begin
      @(negedge clk);
      n_checks++;
      if (state !== 2'(m_state)) begin
        n_fail++; $display("FAIL state_track t=%0t: got %0d want %0d", $time, state, m_state);
      end
      n_checks++;
      if (lives !== 2'(m_lives)) begin
        n_fail++; $display("FAIL lives_track t=%0t: got %0d want %0d", $time, lives, m_lives);
      end
      n_checks++;
      if (frame_div !== 4'(m_div)) begin
        n_fail++; $display("FAIL div_track t=%0t: got %0d want %0d", $time, frame_div, m_div);
      end
      n_checks++;
      if (frame_tick !== 1'(m_ft)) begin
        n_fail++; $display("FAIL tick_track t=%0t: got %0b want %0d", $time, frame_tick, m_ft);
      end
      n_checks++;
      if (ball_rst !== 1'(m_brst)) begin
        n_fail++; $display("FAIL brst_track t=%0t: got %0b want %0d", $time, ball_rst, m_brst);
      end
      if (move === 1'b1) begin
        n_checks++;
        if (ball_rst !== 1'b0) begin
          n_fail++; $display("FAIL brst_with_move t=%0t: got ball_rst=%0b want 0", $time, ball_rst);
        end
        if (pixpulse) pp++;
        if (rst) trunc = 1;
      end
      if (move === 1'b1 && mv_prev == 0) begin
        n_move_rise++;
        n_checks++;
        if (ft_prev != 1) begin
          n_fail++; $display("FAIL move_start t=%0t: frame_tick prev clk %0d want 1", $time, ft_prev);
        end
        n_checks++;
        if (m_state != 1) begin
          n_fail++; $display("FAIL move_in_run t=%0t: state %0d want 1", $time, m_state);
        end
      end
      if (move !== 1'b1 && mv_prev == 1) begin
        if (trunc == 0) begin
          n_checks++;
          if (pp != 1) begin
            n_fail++; $display("FAIL move_width t=%0t: pixpulse clks %0d want 1", $time, pp);
          end
        end
        pp = 0; trunc = 0;
      end
      if (ball_rst === 1'b1 && br_prev == 0) n_brst_rise++;
      mv_prev = (move === 1'b1) ? 1 : 0;
      br_prev = (ball_rst === 1'b1) ? 1 : 0;
      ft_prev = m_ft;
    end
  end

  // Lands at posedge+1 of a clk in which frame_tick is low.
  task automatic tick_safe();
    @(posedge clk); #1;
    while (m_ft != 0) begin @(posedge clk); #1; end
  endtask

  task automatic press_serve();
    tick_safe();
    serve_btn = 1'b1;
    repeat (3) @(posedge clk);
    #1 serve_btn = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic press_pause();
    tick_safe();
    pause_btn = 1'b1;
    repeat (3) @(posedge clk);
    #1 pause_btn = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic pulse_speed();
    tick_safe();
    speed_up = 1'b1;
    @(posedge clk);
    #1 speed_up = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int target, budget;
    target = n_frames + n;
    budget = n * FRAME_CLKS + 20;
    while (n_frames < target && budget > 0) begin @(posedge clk); budget--; end
    n_checks++;
    if (n_frames < target) begin
      n_fail++; $display("FAIL wait_frames: saw %0d frames want %0d", n_frames, target);
    end
    repeat (8) @(posedge clk);
  endtask

  task automatic do_miss();
    tick_safe();
    miss = 1'b1;
    wait_frames(1);
    #1 miss = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_checks++; if (lives !== 2'd3) begin n_fail++; $display("FAIL reset_lives: got %0d want 3", lives); end
    n_checks++; if (frame_div !== 4'd4) begin n_fail++; $display("FAIL reset_div: got %0d want 4", frame_div); end
    n_checks++; if (move !== 1'b0) begin n_fail++; $display("FAIL reset_move: got %0b want 0", move); end
    n_checks++; if (ball_rst !== 1'b0) begin n_fail++; $display("FAIL reset_brst: got %0b want 0", ball_rst); end
    n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %0b want 0", frame_tick); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_serve_moves();
    int m0, s0;
    press_serve();
    m0 = n_move_rise; s0 = m_steps;
    wait_frames(20);
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL serve_state: got %0d want 1", state); end
    n_checks++;
    if (n_move_rise - m0 != m_steps - s0) begin
      n_fail++; $display("FAIL serve_moves_model: got %0d want %0d", n_move_rise - m0, m_steps - s0);
    end
`ifndef BALL_SCHED_AUTOSPEED_EN
    n_checks++;
    if (n_move_rise - m0 != 5) begin
      n_fail++; $display("FAIL serve_moves_20f: got %0d want 5", n_move_rise - m0);
    end
`endif
  endtask

  task automatic test_speed_up();
    int m0;
    repeat (3) pulse_speed();
    repeat (5) pulse_speed();
    @(negedge clk);
    n_checks++; if (frame_div !== 4'd1) begin n_fail++; $display("FAIL speed_sat: got %0d want 1", frame_div); end
    m0 = n_move_rise;
    wait_frames(10);
    n_checks++;
    if (n_move_rise - m0 != 10) begin
      n_fail++; $display("FAIL speed_moves_10f: got %0d want 10", n_move_rise - m0);
    end
  endtask

  task automatic test_miss();
    int m0, b0;
    m0 = n_move_rise; b0 = n_brst_rise;
    do_miss();
    n_checks++; if (lives !== 2'd2) begin n_fail++; $display("FAIL miss1_lives: got %0d want 2", lives); end
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL miss1_state: got %0d want 0", state); end
    n_checks++; if (n_brst_rise - b0 != 1) begin n_fail++; $display("FAIL miss1_brst: got %0d want 1", n_brst_rise - b0); end
    n_checks++; if (n_move_rise != m0) begin n_fail++; $display("FAIL miss1_move: got %0d want 0", n_move_rise - m0); end
    press_serve();
    do_miss();
    n_checks++; if (lives !== 2'd1) begin n_fail++; $display("FAIL miss2_lives: got %0d want 1", lives); end
    press_serve();
    do_miss();
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL miss3_state: got %0d want 3", state); end
    n_checks++; if (lives !== 2'd0) begin n_fail++; $display("FAIL miss3_lives: got %0d want 0", lives); end
    b0 = n_brst_rise;
    press_serve();
    n_checks++; if (lives !== 2'd3) begin n_fail++; $display("FAIL restart_lives: got %0d want 3", lives); end
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL restart_state: got %0d want 0", state); end
    n_checks++; if (n_brst_rise - b0 != 1) begin n_fail++; $display("FAIL restart_brst: got %0d want 1", n_brst_rise - b0); end
  endtask

  task automatic test_pause();
    int m0;
    press_serve();
    m0 = n_move_rise;
    wait_frames(2);
    press_pause();
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL pause_state: got %0d want 2", state); end
    wait_frames(10);
    n_checks++; if (n_move_rise != m0) begin n_fail++; $display("FAIL pause_moves: got %0d want 0", n_move_rise - m0); end
    press_pause();
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL resume_state: got %0d want 1", state); end
    wait_frames(1);
    n_checks++; if (n_move_rise != m0) begin n_fail++; $display("FAIL resume_early: got %0d want 0", n_move_rise - m0); end
    wait_frames(1);
    n_checks++; if (n_move_rise - m0 != 1) begin n_fail++; $display("FAIL resume_move: got %0d want 1", n_move_rise - m0); end
  endtask

  task automatic test_pause_miss();
    int b, ok;
    b = 0; ok = 0;
    while (ok == 0 && b < FRAME_CLKS + 10) begin
      @(posedge clk); #1;
      if (m_ft != 0) ok = 1;
      b++;
    end
    n_checks++; if (ok == 0) begin n_fail++; $display("FAIL pm_tick_wait: got no tick want 1"); end
    pause_btn = 1'b1;
    miss = 1'b1;
    @(posedge clk); #1 miss = 1'b0;
    @(negedge clk);
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL pm_state: got %0d want 0", state); end
    n_checks++; if (lives !== 2'd2) begin n_fail++; $display("FAIL pm_lives: got %0d want 2", lives); end
    repeat (3) @(posedge clk);
    #1 pause_btn = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid_move();
    int b;
    press_serve();
    b = 0;
    while (move !== 1'b1 && b < 6 * FRAME_CLKS) begin @(negedge clk); b++; end
    n_checks++; if (move !== 1'b1) begin n_fail++; $display("FAIL rmm_wait: got move %0b want 1", move); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (move !== 1'b0) begin n_fail++; $display("FAIL rmm_move: got %0b want 0", move); end
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL rmm_state: got %0d want 0", state); end
    n_checks++; if (lives !== 2'd3) begin n_fail++; $display("FAIL rmm_lives: got %0d want 3", lives); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_autospeed();
    int exp_div, m0, s0;
    press_serve();
    m0 = n_move_rise; s0 = m_steps;
    for (int k = 0; k < 3; k++) begin
      wait_frames(8);
`ifdef BALL_SCHED_AUTOSPEED_EN
      exp_div = 3 - k;
`else
      exp_div = 4;
`endif
      n_checks++;
      if (frame_div !== 4'(exp_div)) begin
        n_fail++; $display("FAIL autospeed_div%0d: got %0d want %0d", k, frame_div, exp_div);
      end
    end
    n_checks++;
    if (n_move_rise - m0 != m_steps - s0) begin
      n_fail++; $display("FAIL autospeed_moves: got %0d want %0d", n_move_rise - m0, m_steps - s0);
    end
  endtask

  task automatic test_random();
    int m0, s0, r;
    m0 = n_move_rise; s0 = m_steps;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      speed_up = 1'b0;
      if (m_ft == 0) begin
        r = int'($urandom_range(0, 999));
        if (r < 6)       serve_btn = ~serve_btn;
        else if (r < 10) pause_btn = ~pause_btn;
        else if (r < 14) speed_up = 1'b1;
        else if (r < 19) miss = ~miss;
      end
    end
    @(posedge clk); #1;
    speed_up = 1'b0; serve_btn = 1'b0; pause_btn = 1'b0; miss = 1'b0;
    repeat (10) @(posedge clk);
    n_checks++;
    if (n_move_rise - m0 != m_steps - s0) begin
      n_fail++; $display("FAIL random_moves: got %0d want %0d", n_move_rise - m0, m_steps - s0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_serve_moves();
    test_speed_up();
    test_miss();
    test_pause();
    test_pause_miss();
    test_reset_mid_move();
    test_autospeed();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
